// File: rtl/commit_retire.sv
// commit_retire: in-order retirement of the scoreboard commit window.
// Retires up to two head entries per cycle, raises precise exceptions and
// sequences store release, CSR access, FENCE and AMO handshakes.
// Optional feature: define COMMIT_INSTRET_CNT_EN to add the 64-bit
// instret_cnt_o running count of retired instructions.

package commit_retire_pkg;
   localparam int XLEN = 64;

   typedef enum logic [2:0] {
      FU_NONE, FU_ALU, FU_LOAD, FU_STORE, FU_CSR, FU_FPU, FU_BRANCH
   } fu_t;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_LD, OP_SD, OP_CSRRW, OP_FENCE, OP_FENCE_I,
      OP_SFENCE_VMA, OP_AMO_SWAP, OP_AMO_ADD, OP_FADD, OP_FLD, OP_BEQ
   } op_t;

   typedef struct packed {
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
      logic            valid;
   } exception_t;

   typedef struct packed {
      logic            valid;
      fu_t             fu;
      op_t             op;
      logic [4:0]      rd;
      logic [XLEN-1:0] result;
      exception_t      ex;
   } scoreboard_entry_t;

   function automatic logic is_rd_fpr(input op_t op);
      return (op == OP_FADD) || (op == OP_FLD);
   endfunction

   function automatic logic is_fence(input op_t op);
      return (op == OP_FENCE) || (op == OP_FENCE_I) || (op == OP_SFENCE_VMA);
   endfunction

   function automatic logic is_amo(input op_t op);
      return (op == OP_AMO_SWAP) || (op == OP_AMO_ADD);
   endfunction
endpackage

module commit_retire
   import commit_retire_pkg::*;
#(
   parameter int unsigned NR_COMMIT_PORTS = 2
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   halt_i,
   input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i,
   output logic [NR_COMMIT_PORTS-1:0]             commit_ack_o,
   output logic [NR_COMMIT_PORTS-1:0][4:0]        waddr_o,
   output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]   wdata_o,
   output logic [NR_COMMIT_PORTS-1:0]             we_gpr_o,
   output logic [NR_COMMIT_PORTS-1:0]             we_fpr_o,
   output exception_t                             exception_o,
   output logic                                   commit_lsu_o,
   input  logic                                   commit_lsu_ready_i,
   output logic                                   csr_commit_o,
   input  logic [XLEN-1:0]                        csr_rdata_i,
   input  exception_t                             csr_exception_i,
   output logic                                   fence_req_o,
   input  logic                                   fence_done_i,
   output logic                                   amo_req_o,
   input  logic                                   amo_resp_i,
   input  logic [XLEN-1:0]                        amo_result_i,
   output logic                                   flush_commit_o,
   output logic [1:0]                             instret_o
`ifdef COMMIT_INSTRET_CNT_EN
   ,
   output logic [63:0]                            instret_cnt_o
`endif
);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] WAIT_FENCE = 2'd1;
   localparam logic [1:0] WAIT_AMO   = 2'd2;

   logic [1:0]        state_p1, state_d;
   logic              flush_p1, flush_d;
   logic              ok0, ok1, pair_ok;
   scoreboard_entry_t e0, e1;
   logic              unused_fields;

   assign e0 = commit_instr_i[0];
   assign e1 = commit_instr_i[1];
   // Port 1 exceptions are never reported, so their payload is not consumed.
   assign unused_fields = ^{e1.ex.cause, e1.ex.tval};

   // Retirement decision, register writes and handshake requests.
   // Everything is held at zero while reset is asserted.
   always_comb begin
      commit_ack_o = '0;
      waddr_o      = '0;
      wdata_o      = '0;
      we_gpr_o     = '0;
      we_fpr_o     = '0;
      exception_o  = '0;
      commit_lsu_o = 1'b0;
      csr_commit_o = 1'b0;
      fence_req_o  = 1'b0;
      amo_req_o    = 1'b0;
      state_d      = state_p1;
      flush_d      = 1'b0;
      ok0          = 1'b0;
      ok1          = 1'b0;
      pair_ok      = 1'b0;
      if (rst_ni) begin
         waddr_o[0] = e0.rd;
         waddr_o[1] = e1.rd;
         wdata_o[0] = e0.result;
         wdata_o[1] = e1.result;
         case (state_p1)
            IDLE: begin
               if (e0.valid && !halt_i) begin
                  if (e0.ex.valid) begin
                     commit_ack_o[0] = 1'b1;
                     exception_o     = e0.ex;
                  end else if (is_fence(e0.op)) begin
                     fence_req_o = 1'b1;
                     state_d     = WAIT_FENCE;
                  end else if (is_amo(e0.op)) begin
                     amo_req_o = 1'b1;
                     state_d   = WAIT_AMO;
                  end else if (e0.fu == FU_CSR) begin
                     csr_commit_o    = 1'b1;
                     wdata_o[0]      = csr_rdata_i;
                     commit_ack_o[0] = 1'b1;
                     flush_d         = 1'b1;
                     if (csr_exception_i.valid) exception_o = csr_exception_i;
                     else                       ok0         = 1'b1;
                  end else if (e0.fu == FU_STORE) begin
                     if (commit_lsu_ready_i) begin
                        commit_ack_o[0] = 1'b1;
                        commit_lsu_o    = 1'b1;
                        ok0             = 1'b1;
                        pair_ok         = 1'b1;
                     end
                  end else begin
                     commit_ack_o[0] = 1'b1;
                     ok0             = 1'b1;
                     pair_ok         = 1'b1;
                  end
               end
            end
            WAIT_FENCE: begin
               if (fence_done_i) begin
                  commit_ack_o[0] = 1'b1;
                  ok0             = 1'b1;
                  flush_d         = 1'b1;
                  state_d         = IDLE;
               end
            end
            WAIT_AMO: begin
               if (amo_resp_i) begin
                  commit_ack_o[0] = 1'b1;
                  wdata_o[0]      = amo_result_i;
                  ok0             = 1'b1;
                  flush_d         = 1'b1;
                  state_d         = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase

         // Port 1 only rides along with a plain, non-exceptional port 0.
         if (pair_ok && e1.valid && !e1.ex.valid && (e1.fu != FU_STORE) &&
             (e1.fu != FU_CSR) && !is_fence(e1.op) && !is_amo(e1.op)) begin
            commit_ack_o[1] = 1'b1;
            ok1             = 1'b1;
         end

         we_fpr_o[0] = ok0 && is_rd_fpr(e0.op);
         we_gpr_o[0] = ok0 && !is_rd_fpr(e0.op) && (e0.rd != 5'd0);
         we_fpr_o[1] = ok1 && is_rd_fpr(e1.op);
         we_gpr_o[1] = ok1 && !is_rd_fpr(e1.op) && (e1.rd != 5'd0);
         // The younger instruction wins a same-register collision.
         if (we_gpr_o[0] && we_gpr_o[1] && (e0.rd == e1.rd)) we_gpr_o[0] = 1'b0;
         if (we_fpr_o[0] && we_fpr_o[1] && (e0.rd == e1.rd)) we_fpr_o[0] = 1'b0;
      end
      instret_o = {1'b0, ok0} + {1'b0, ok1};
   end

   // State and the one-cycle-delayed flush; reset abandons any pending wait.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_p1 <= IDLE;
         flush_p1 <= 1'b0;
      end else begin
         state_p1 <= state_d;
         flush_p1 <= flush_d;
      end
   end

   assign flush_commit_o = flush_p1;

`ifdef COMMIT_INSTRET_CNT_EN
   logic [63:0] instret_cnt_p1;

   // Free-running retired-instruction count, wraps modulo 2^64.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) instret_cnt_p1 <= '0;
      else         instret_cnt_p1 <= instret_cnt_p1 + 64'(instret_o);
   end

   assign instret_cnt_o = instret_cnt_p1;
`endif

endmodule
